// File: rtl/rbm_visible_recon.sv
// Downward RBM pass: serially reconstructs each visible unit as a hard-sigmoid of
// c(v) + sum of W(v,h) over active hidden bits, then samples it against a Galois LFSR.
module rbm_visible_recon #(
  parameter int unsigned weight_bitlength = 12,
  parameter int unsigned sg_bitlength     = 8,
  parameter int unsigned vis_dim          = 6,
  parameter int unsigned hid_dim          = 5,
  parameter int unsigned acc_bitlength    = 16,
  parameter int unsigned sg_shift         = 2,
  parameter int unsigned lfsr_seed        = 32'hA5
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [hid_dim-1:0]                           HiddenI,
  input  logic [vis_dim*hid_dim*weight_bitlength-1:0]  WeightI,
  input  logic [vis_dim*weight_bitlength-1:0]          BiasI,
  output logic                                         busy,
  output logic                                         done,
  output logic [vis_dim*sg_bitlength-1:0]              VprobO,
  output logic [vis_dim-1:0]                           VsampleO
);

  localparam int unsigned v_w = (vis_dim > 1) ? $clog2(vis_dim) : 1;
  localparam int unsigned h_w = (hid_dim > 1) ? $clog2(hid_dim) : 1;
  localparam logic [v_w-1:0] v_last = v_w'(vis_dim - 1);
  localparam logic [h_w-1:0] h_last = h_w'(hid_dim - 1);

  localparam logic signed [acc_bitlength-1:0] x_max = acc_bitlength'((2 ** (weight_bitlength - 1)) - 1);
  localparam logic signed [acc_bitlength-1:0] x_min = acc_bitlength'(-(2 ** (weight_bitlength - 1)));
  localparam logic signed [acc_bitlength-1:0] y_off = acc_bitlength'(2 ** (sg_bitlength - 1));
  localparam logic signed [acc_bitlength-1:0] p_max = acc_bitlength'((2 ** sg_bitlength) - 1);

  // Right-shifting Galois feedback masks for maximal-length LFSRs.
  function automatic logic [sg_bitlength-1:0] lfsr_taps();
    logic [31:0] t;
    case (sg_bitlength)
      3:       t = 32'h6;
      4:       t = 32'hC;
      5:       t = 32'h14;
      6:       t = 32'h30;
      7:       t = 32'h60;
      9:       t = 32'h110;
      10:      t = 32'h240;
      11:      t = 32'h500;
      12:      t = 32'hE08;
      13:      t = 32'h1C80;
      14:      t = 32'h3802;
      15:      t = 32'h6000;
      16:      t = 32'hB400;
      default: t = 32'hB8;
    endcase
    return sg_bitlength'(t);
  endfunction

  localparam logic [sg_bitlength-1:0] taps = lfsr_taps();
  localparam logic [sg_bitlength-1:0] seed =
      (sg_bitlength'(lfsr_seed) == '0) ? sg_bitlength'(1) : sg_bitlength'(lfsr_seed);

  typedef enum logic [1:0] {IDLE, ACCUM, ACTIVATE, DONE} state_t;

  state_t                           state_q, state_d;
  logic [v_w-1:0]                   v_q;
  logic [h_w-1:0]                   h_q;
  logic [hid_dim-1:0]               h_latch;
  logic signed [acc_bitlength-1:0]  acc_q;
  logic [sg_bitlength-1:0]          lfsr_q;

  logic [v_w-1:0]                   b_idx;
  logic signed [weight_bitlength-1:0] w_sel;
  logic signed [weight_bitlength-1:0] b_sel;
  logic signed [acc_bitlength-1:0]  x_sat;
  logic signed [acc_bitlength-1:0]  y_val;
  logic [sg_bitlength-1:0]          p_val;
  logic [sg_bitlength-1:0]          lfsr_next;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = ACCUM;
      ACCUM:    if (h_q == h_last) state_d = ACTIVATE;
      ACTIVATE: state_d = (v_q == v_last) ? DONE : ACCUM;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  // Operand selection; the bias index looks one unit ahead while activating.
  always_comb begin
    b_idx = '0;
    if (state_q == ACTIVATE && v_q != v_last) b_idx = v_q + v_w'(1);
    w_sel = WeightI[(int'(v_q) * hid_dim + int'(h_q)) * weight_bitlength +: weight_bitlength];
    b_sel = BiasI[int'(b_idx) * weight_bitlength +: weight_bitlength];
  end

  // Saturate, hard-sigmoid and clamp to the probability range.
  always_comb begin
    x_sat = acc_q;
    if (acc_q > x_max)      x_sat = x_max;
    else if (acc_q < x_min) x_sat = x_min;
    y_val = (x_sat >>> sg_shift) + y_off;
    if (y_val < 0)          p_val = '0;
    else if (y_val > p_max) p_val = '1;
    else                    p_val = sg_bitlength'(y_val);
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps : '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q      <= '0;
      h_q      <= '0;
      h_latch  <= '0;
      acc_q    <= '0;
      lfsr_q   <= seed;
      VprobO   <= '0;
      VsampleO <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            h_latch <= HiddenI;
            v_q     <= '0;
            h_q     <= '0;
            acc_q   <= acc_bitlength'(b_sel);
          end
        end
        ACCUM: begin
          if (h_latch[h_q]) acc_q <= acc_q + acc_bitlength'(w_sel);
          h_q <= (h_q == h_last) ? '0 : h_q + h_w'(1);
        end
        ACTIVATE: begin
          VprobO[int'(v_q) * sg_bitlength +: sg_bitlength] <= p_val;
          VsampleO[v_q] <= (p_val > lfsr_q);
          lfsr_q        <= lfsr_next;
          if (v_q != v_last) begin
            v_q   <= v_q + v_w'(1);
            acc_q <= acc_bitlength'(b_sel);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_visible_recon.sv
// Scenario bench for rbm_visible_recon: an independent reference model pushes expected
// outputs into a scoreboard at start time; each scenario pops and compares at done.
module tb_rbm_visible_recon;

  localparam int WB = 12;
  localparam int SG = 8;
  localparam int VD = 6;
  localparam int HD = 5;
  localparam int LAT = 37;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic [HD-1:0] HiddenI;
  logic [VD*HD*WB-1:0] WeightI;
  logic [VD*WB-1:0] BiasI;
  logic busy, done;
  logic [VD*SG-1:0] VprobO;
  logic [VD-1:0] VsampleO;

  always #5 clock = ~clock;

  rbm_visible_recon dut (
    .clock(clock), .reset(reset), .start(start), .HiddenI(HiddenI), .WeightI(WeightI),
    .BiasI(BiasI), .busy(busy), .done(done), .VprobO(VprobO), .VsampleO(VsampleO)
  );

  typedef struct packed {
    logic [VD*SG-1:0] prob;
    logic [VD-1:0]    samp;
  } exp_t;

  exp_t sb[$];
  exp_t first_exp;
  logic [VD*HD*WB-1:0] first_w;
  logic [VD*WB-1:0] first_b;
  logic [HD-1:0] first_h;
  logic [7:0] m_lfsr;
  int n_pass = 0;
  int n_total = 0;

  task automatic fill_uniform(input logic [WB-1:0] wv, input logic [WB-1:0] cv);
    for (int i = 0; i < VD*HD; i++) WeightI[i*WB +: WB] = wv;
    for (int i = 0; i < VD; i++) BiasI[i*WB +: WB] = cv;
  endtask

  task automatic fill_random();
    for (int i = 0; i < VD*HD; i++) WeightI[i*WB +: WB] = WB'($urandom);
    for (int i = 0; i < VD; i++) BiasI[i*WB +: WB] = WB'($urandom);
  endtask

  // Reference model: integer accumulate, saturate, hard-sigmoid, LFSR compare.
  task automatic model_push();
    exp_t e;
    int acc, x, y;
    e = '0;
    for (int v = 0; v < VD; v++) begin
      acc = int'($signed(BiasI[v*WB +: WB]));
      for (int h = 0; h < HD; h++)
        if (HiddenI[h]) acc += int'($signed(WeightI[(v*HD+h)*WB +: WB]));
      x = (acc > 2047) ? 2047 : ((acc < -2048) ? -2048 : acc);
      y = (x >>> 2) + 128;
      y = (y < 0) ? 0 : ((y > 255) ? 255 : y);
      e.prob[v*SG +: SG] = 8'(y);
      e.samp[v] = (8'(y) > m_lfsr);
      m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end
    sb.push_back(e);
  endtask

  // Start accepted at the posedge between the two negedges; returns in cycle k+1.
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int s1, input int s2, output int cyc, output int busy_drops);
    cyc = 1;
    busy_drops = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_drops++;
      @(negedge clock);
      cyc++;
      start = (cyc == s1 || cyc == s2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; HiddenI = '0; WeightI = '0; BiasI = '0;
    reset = 1'b0;
    m_lfsr = 8'hA5;
    repeat (3) @(negedge clock);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_total++; if (VprobO !== '0) $display("FAIL reset_prob got %h exp 0", VprobO); else n_pass++;
    n_total++; if (VsampleO !== '0) $display("FAIL reset_samp got %b exp 0", VsampleO); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_zero_hidden();
    exp_t e; int cyc, bd;
    fill_random();
    BiasI = '0;
    HiddenI = '0;
    model_push();
    first_w = WeightI; first_b = BiasI; first_h = HiddenI; first_exp = sb[sb.size()-1];
    pulse_start();
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (cyc !== LAT) $display("FAIL zero_latency got %0d exp %0d", cyc, LAT); else n_pass++;
    n_total++; if (bd !== 0) $display("FAIL zero_busy_drops got %0d exp 0", bd); else n_pass++;
    n_total++; if (VprobO !== e.prob) $display("FAIL zero_prob got %h exp %h", VprobO, e.prob); else n_pass++;
    n_total++; if (VsampleO !== e.samp) $display("FAIL zero_samp got %b exp %b", VsampleO, e.samp); else n_pass++;
    for (int v = 0; v < VD; v++) begin
      n_total++;
      if (VprobO[v*SG +: SG] !== 8'h80) $display("FAIL zero_p%0d got %h exp 80", v, VprobO[v*SG +: SG]);
      else n_pass++;
    end
  endtask

  task automatic test_uniform();
    exp_t e; int cyc, bd;
    fill_uniform(12'h010, 12'h000);
    HiddenI = 5'b11111;
    model_push();
    pulse_start();
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (VsampleO !== e.samp) $display("FAIL uni_all_samp got %b exp %b", VsampleO, e.samp); else n_pass++;
    for (int v = 0; v < VD; v++) begin
      n_total++;
      if (VprobO[v*SG +: SG] !== 8'd148) $display("FAIL uni_all_p%0d got %0d exp 148", v, VprobO[v*SG +: SG]);
      else n_pass++;
    end
    HiddenI = 5'b00101;
    model_push();
    pulse_start();
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (VsampleO !== e.samp) $display("FAIL uni_sub_samp got %b exp %b", VsampleO, e.samp); else n_pass++;
    for (int v = 0; v < VD; v++) begin
      n_total++;
      if (VprobO[v*SG +: SG] !== 8'd136) $display("FAIL uni_sub_p%0d got %0d exp 136", v, VprobO[v*SG +: SG]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    exp_t e; int cyc, bd;
    fill_uniform(12'h7FF, 12'h000);
    HiddenI = 5'b11111;
    model_push();
    pulse_start();
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (VprobO !== {VD{8'hFF}}) $display("FAIL sat_pos_prob got %h exp all ff", VprobO); else n_pass++;
    n_total++; if (VsampleO !== e.samp) $display("FAIL sat_pos_samp got %b exp %b", VsampleO, e.samp); else n_pass++;
    fill_uniform(12'h800, 12'h000);
    model_push();
    pulse_start();
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (VprobO !== '0) $display("FAIL sat_neg_prob got %h exp 0", VprobO); else n_pass++;
    n_total++; if (VsampleO !== '0) $display("FAIL sat_neg_samp got %b exp 0", VsampleO); else n_pass++;
    n_total++; if (e.samp !== VsampleO) $display("FAIL sat_neg_model got %b exp %b", VsampleO, e.samp); else n_pass++;
  endtask

  task automatic test_mixed();
    exp_t e; int cyc, bd;
    fill_random();
    BiasI[2*WB +: WB] = 12'hFF0;
    for (int h = 0; h < HD; h++) WeightI[(2*HD+h)*WB +: WB] = 12'h004;
    HiddenI = 5'b11111;
    model_push();
    pulse_start();
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (VprobO[2*SG +: SG] !== 8'd129) $display("FAIL mixed_p2 got %0d exp 129", VprobO[2*SG +: SG]); else n_pass++;
    n_total++; if (VprobO !== e.prob) $display("FAIL mixed_prob got %h exp %h", VprobO, e.prob); else n_pass++;
    n_total++; if (VsampleO !== e.samp) $display("FAIL mixed_samp got %b exp %b", VsampleO, e.samp); else n_pass++;
  endtask

  task automatic test_random();
    exp_t e; int cyc, bd;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      HiddenI = HD'($urandom);
      model_push();
      pulse_start();
      wait_done(0, 0, cyc, bd);
      e = sb.pop_front();
      n_total++; if (VprobO !== e.prob) $display("FAIL rand%0d_prob got %h exp %h", it, VprobO, e.prob); else n_pass++;
      n_total++; if (VsampleO !== e.samp) $display("FAIL rand%0d_samp got %b exp %b", it, VsampleO, e.samp); else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    exp_t e; int cyc, bd, extra;
    fill_random();
    HiddenI = 5'b10110;
    model_push();
    pulse_start();
    wait_done(5, 20, cyc, bd);
    e = sb.pop_front();
    n_total++; if (cyc !== LAT) $display("FAIL ign_latency got %0d exp %0d", cyc, LAT); else n_pass++;
    n_total++; if (bd !== 0) $display("FAIL ign_busy_drops got %0d exp 0", bd); else n_pass++;
    n_total++; if (VprobO !== e.prob) $display("FAIL ign_prob got %h exp %h", VprobO, e.prob); else n_pass++;
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL ign_rerun got %0d active cycles exp 0", extra); else n_pass++;
  endtask

  task automatic test_start_held();
    exp_t e; int cyc, bd;
    fill_random();
    HiddenI = 5'b01011;
    model_push();
    model_push();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    e = sb.pop_front();
    n_total++; if (cyc !== LAT) $display("FAIL held_latency1 got %0d exp %0d", cyc, LAT); else n_pass++;
    n_total++; if (VprobO !== e.prob) $display("FAIL held_prob1 got %h exp %h", VprobO, e.prob); else n_pass++;
    @(negedge clock);
    n_total++; if (busy !== 1'b0) $display("FAIL held_idle_busy got %b exp 0", busy); else n_pass++;
    @(negedge clock);
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL held_accept_busy got %b exp 1", busy); else n_pass++;
    wait_done(0, 0, cyc, bd);
    e = sb.pop_front();
    n_total++; if (cyc !== LAT) $display("FAIL held_latency2 got %0d exp %0d", cyc, LAT); else n_pass++;
    n_total++; if (VsampleO !== e.samp) $display("FAIL held_samp2 got %b exp %b", VsampleO, e.samp); else n_pass++;
    n_total++; if (VprobO !== e.prob) $display("FAIL held_prob2 got %h exp %h", VprobO, e.prob); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int cyc, bd;
    WeightI = first_w; BiasI = first_b; HiddenI = first_h;
    pulse_start();
    repeat (19) @(negedge clock);
    reset = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (VprobO !== '0) $display("FAIL mid_prob got %h exp 0", VprobO); else n_pass++;
    n_total++; if (VsampleO !== '0) $display("FAIL mid_samp got %b exp 0", VsampleO); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pulse_start();
    wait_done(0, 0, cyc, bd);
    n_total++; if (cyc !== LAT) $display("FAIL rerun_latency got %0d exp %0d", cyc, LAT); else n_pass++;
    n_total++; if (VprobO !== first_exp.prob) $display("FAIL rerun_prob got %h exp %h", VprobO, first_exp.prob); else n_pass++;
    n_total++; if (VsampleO !== first_exp.samp) $display("FAIL rerun_samp got %b exp %b", VsampleO, first_exp.samp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_hidden();
    test_uniform();
    test_saturation();
    test_mixed();
    test_random();
    test_ignored_start();
    test_start_held();
    test_reset_midrun();
    n_total++; if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
